// File: rtl/register_bank_arbiter_if.sv
// rtl/register_bank_arbiter_if.sv - one requester's access port onto the shared register bank
interface register_bank_arbiter_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
);
    logic              req;
    logic              we;
    logic [SEL_W-1:0]  sel;
    logic              indirect;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (
        output req, we, sel, indirect, wdata,
        input  gnt, rdata, rvalid
    );

    modport slave (
        input  req, we, sel, indirect, wdata,
        output gnt, rdata, rvalid
    );
endinterface

// File: rtl/register_bank_arbiter.sv
// rtl/register_bank_arbiter.sv - clears the 8x8 register bank after reset, then arbitrates A/B round-robin
module register_bank_arbiter #(
    parameter int DATA_W   = 8,
    parameter int SEL_W    = 3,
    parameter bit CLEAR_EN = 1'b1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    register_bank_arbiter_if.slave io_a,
    register_bank_arbiter_if.slave io_b,
    output logic                 o_rb_write_en,
    output logic                 o_rb_read_en,
    output logic [SEL_W-1:0]     o_rb_rx_sel,
    output logic [SEL_W-1:0]     o_rb_ry_sel,
    output logic                 o_rb_indirect,
    output logic [DATA_W-1:0]    o_rb_wdata,
    input  logic [DATA_W-1:0]    i_rb_bus_data,
    output logic                 o_busy
);
    typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SEL_W-1:0]  r_clr_cnt;
    logic              r_rr_ptr;      // 0: A wins a tie, 1: B wins a tie
    logic              r_a_rvalid;
    logic              r_b_rvalid;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;

    logic w_run;
    logic w_a_gnt;
    logic w_b_gnt;

    assign w_run   = (r_state == ST_RUN);
    assign w_a_gnt = w_run && io_a.req && (!io_b.req || !r_rr_ptr);
    assign w_b_gnt = w_run && io_b.req && (!io_a.req ||  r_rr_ptr);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= CLEAR_EN ? ST_CLEAR : ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The counter is all ones on the last clear write
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == ST_CLEAR && r_clr_cnt == '1) begin
            w_state_nxt = ST_RUN;
        end
    end

    always_comb begin
        o_rb_write_en = 1'b0;
        o_rb_read_en  = 1'b0;
        o_rb_rx_sel   = '0;
        o_rb_ry_sel   = '0;
        o_rb_indirect = 1'b0;
        o_rb_wdata    = '0;
        o_busy        = 1'b0;
        if (r_state == ST_CLEAR) begin
            o_rb_write_en = 1'b1;
            o_rb_rx_sel   = r_clr_cnt;
            o_busy        = 1'b1;
        end else if (w_a_gnt) begin
            if (io_a.we) begin
                o_rb_write_en = 1'b1;
                o_rb_rx_sel   = io_a.sel;
                o_rb_wdata    = io_a.wdata;
            end else begin
                o_rb_read_en  = 1'b1;
                o_rb_ry_sel   = io_a.sel;
                o_rb_indirect = io_a.indirect;
            end
        end else if (w_b_gnt) begin
            if (io_b.we) begin
                o_rb_write_en = 1'b1;
                o_rb_rx_sel   = io_b.sel;
                o_rb_wdata    = io_b.wdata;
            end else begin
                o_rb_read_en  = 1'b1;
                o_rb_ry_sel   = io_b.sel;
                o_rb_indirect = io_b.indirect;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_clr_cnt  <= '0;
            r_rr_ptr   <= 1'b0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
            if (w_a_gnt) begin
                r_rr_ptr <= 1'b1;
            end else if (w_b_gnt) begin
                r_rr_ptr <= 1'b0;
            end
            r_a_rvalid <= w_a_gnt && !io_a.we;
            r_b_rvalid <= w_b_gnt && !io_b.we;
            if (w_a_gnt && !io_a.we) begin
                r_a_rdata <= i_rb_bus_data;
            end
            if (w_b_gnt && !io_b.we) begin
                r_b_rdata <= i_rb_bus_data;
            end
        end
    end

    assign io_a.gnt    = w_a_gnt;
    assign io_a.rvalid = r_a_rvalid;
    assign io_a.rdata  = r_a_rdata;
    assign io_b.gnt    = w_b_gnt;
    assign io_b.rvalid = r_b_rvalid;
    assign io_b.rdata  = r_b_rdata;
endmodule

// File: tb/tb_register_bank_arbiter.sv
// tb/tb_register_bank_arbiter.sv - directed vector bench for register_bank_arbiter with a behavioural 8x8 bank
module tb_register_bank_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       rb_write_en, rb_read_en, rb_indirect, busy;
    logic [2:0] rb_rx_sel, rb_ry_sel;
    logic [7:0] rb_wdata, rb_bus_data;

    register_bank_arbiter_if #(.DATA_W(8), .SEL_W(3)) a_if ();
    register_bank_arbiter_if #(.DATA_W(8), .SEL_W(3)) b_if ();

    register_bank_arbiter #(.DATA_W(8), .SEL_W(3), .CLEAR_EN(1'b1)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .io_a          (a_if.slave),
        .io_b          (b_if.slave),
        .o_rb_write_en (rb_write_en),
        .o_rb_read_en  (rb_read_en),
        .o_rb_rx_sel   (rb_rx_sel),
        .o_rb_ry_sel   (rb_ry_sel),
        .o_rb_indirect (rb_indirect),
        .o_rb_wdata    (rb_wdata),
        .i_rb_bus_data (rb_bus_data),
        .o_busy        (busy)
    );

    // Behavioural bank, seeded non-zero so the clear sweep is observable
    logic [7:0] bank [8];
    logic       seeded = 1'b0;
    logic [7:0] ptr;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < 8; i++) bank[i] <= 8'hFF;
            seeded <= 1'b1;
        end else if (rb_write_en === 1'b1) begin
            bank[rb_rx_sel] <= rb_wdata;
        end
    end
    assign ptr         = bank[rb_ry_sel];
    assign rb_bus_data = rb_indirect ? bank[ptr[2:0]] : ptr;

    typedef struct {
        logic a_req; logic a_we; logic [2:0] a_sel; logic a_ind; logic [7:0] a_wd;
        logic b_req; logic b_we; logic [2:0] b_sel; logic b_ind; logic [7:0] b_wd;
        logic e_a_gnt; logic e_b_gnt; logic e_we; logic e_re;
        logic [2:0] e_rx; logic [2:0] e_ry; logic e_ind; logic [7:0] e_wd;
        logic e_a_rv; logic [7:0] e_a_rd; logic e_b_rv; logic [7:0] e_b_rd;
    } vec_t;

    vec_t vecs [10];
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    endtask

    task automatic drive_a(input logic req, input logic we, input logic [2:0] sel, input logic ind, input logic [7:0] wd);
        a_if.req = req; a_if.we = we; a_if.sel = sel; a_if.indirect = ind; a_if.wdata = wd;
    endtask

    task automatic drive_b(input logic req, input logic we, input logic [2:0] sel, input logic ind, input logic [7:0] wd);
        b_if.req = req; b_if.we = we; b_if.sel = sel; b_if.indirect = ind; b_if.wdata = wd;
    endtask

    task automatic check_clear(input int n_cyc, input int start);
        for (int i = 0; i < n_cyc; i++) begin
            @(negedge clk); #1;
            chk("clr_busy", 32'(busy), 32'd1);
            chk("clr_we", 32'(rb_write_en), 32'd1);
            chk("clr_sel", 32'(rb_rx_sel), 32'(start + i));
            chk("clr_wdata", 32'(rb_wdata), 32'd0);
            chk("clr_a_gnt", 32'(a_if.gnt), 32'd0);
            chk("clr_b_gnt", 32'(b_if.gnt), 32'd0);
            @(posedge clk);
        end
    endtask

    initial begin
        // a: req we sel ind wd | b: req we sel ind wd | gA gB we re rx ry ind wd | aRv aRd bRv bRd
        vecs[0] = '{1'b0,1'b0,3'd0,1'b0,8'h00, 1'b0,1'b0,3'd0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,8'h00, 1'b0,8'h00,1'b0,8'h00};
        vecs[1] = '{1'b1,1'b0,3'd5,1'b0,8'h00, 1'b0,1'b0,3'd0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b1,3'd0,3'd5,1'b0,8'h00, 1'b1,8'h00,1'b0,8'h00};
        vecs[2] = '{1'b1,1'b1,3'd3,1'b0,8'hA5, 1'b0,1'b0,3'd0,1'b0,8'h00, 1'b1,1'b0,1'b1,1'b0,3'd3,3'd0,1'b0,8'hA5, 1'b0,8'h00,1'b0,8'h00};
        vecs[3] = '{1'b1,1'b0,3'd3,1'b0,8'h00, 1'b0,1'b0,3'd0,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b1,3'd0,3'd3,1'b0,8'h00, 1'b1,8'hA5,1'b0,8'h00};
        vecs[4] = '{1'b1,1'b1,3'd6,1'b0,8'h3C, 1'b1,1'b1,3'd2,1'b0,8'h06, 1'b0,1'b1,1'b1,1'b0,3'd2,3'd0,1'b0,8'h06, 1'b0,8'hA5,1'b0,8'h00};
        vecs[5] = '{1'b1,1'b1,3'd6,1'b0,8'h3C, 1'b1,1'b1,3'd2,1'b0,8'h06, 1'b1,1'b0,1'b1,1'b0,3'd6,3'd0,1'b0,8'h3C, 1'b0,8'hA5,1'b0,8'h00};
        vecs[6] = '{1'b0,1'b0,3'd0,1'b0,8'h00, 1'b1,1'b0,3'd2,1'b1,8'h00, 1'b0,1'b1,1'b0,1'b1,3'd0,3'd2,1'b1,8'h00, 1'b0,8'hA5,1'b1,8'h3C};
        vecs[7] = '{1'b1,1'b0,3'd2,1'b0,8'h00, 1'b1,1'b0,3'd3,1'b0,8'h00, 1'b1,1'b0,1'b0,1'b1,3'd0,3'd2,1'b0,8'h00, 1'b1,8'h06,1'b0,8'h3C};
        vecs[8] = '{1'b1,1'b0,3'd2,1'b0,8'h00, 1'b1,1'b0,3'd3,1'b0,8'h00, 1'b0,1'b1,1'b0,1'b1,3'd0,3'd3,1'b0,8'h00, 1'b0,8'h06,1'b1,8'hA5};
        vecs[9] = '{1'b0,1'b0,3'd0,1'b0,8'h00, 1'b0,1'b0,3'd0,1'b0,8'h00, 1'b0,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,8'h00, 1'b0,8'h06,1'b0,8'hA5};

        rst_n = 1'b0;
        drive_a(1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        drive_b(1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_rvalid", 32'(a_if.rvalid), 32'd0);
        chk("rst_a_rdata", 32'(a_if.rdata), 32'd0);
        chk("rst_b_rvalid", 32'(b_if.rvalid), 32'd0);
        chk("rst_b_rdata", 32'(b_if.rdata), 32'd0);
        rst_n = 1'b1;
        check_clear(8, 0);

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive_a(vecs[k].a_req, vecs[k].a_we, vecs[k].a_sel, vecs[k].a_ind, vecs[k].a_wd);
            drive_b(vecs[k].b_req, vecs[k].b_we, vecs[k].b_sel, vecs[k].b_ind, vecs[k].b_wd);
            #1;
            chk($sformatf("v%0d_busy", k), 32'(busy), 32'd0);
            chk($sformatf("v%0d_a_gnt", k), 32'(a_if.gnt), 32'(vecs[k].e_a_gnt));
            chk($sformatf("v%0d_b_gnt", k), 32'(b_if.gnt), 32'(vecs[k].e_b_gnt));
            chk($sformatf("v%0d_we", k), 32'(rb_write_en), 32'(vecs[k].e_we));
            chk($sformatf("v%0d_re", k), 32'(rb_read_en), 32'(vecs[k].e_re));
            chk($sformatf("v%0d_rx", k), 32'(rb_rx_sel), 32'(vecs[k].e_rx));
            chk($sformatf("v%0d_ry", k), 32'(rb_ry_sel), 32'(vecs[k].e_ry));
            chk($sformatf("v%0d_ind", k), 32'(rb_indirect), 32'(vecs[k].e_ind));
            chk($sformatf("v%0d_wd", k), 32'(rb_wdata), 32'(vecs[k].e_wd));
            @(posedge clk); #1;
            chk($sformatf("v%0d_a_rv", k), 32'(a_if.rvalid), 32'(vecs[k].e_a_rv));
            chk($sformatf("v%0d_a_rd", k), 32'(a_if.rdata), 32'(vecs[k].e_a_rd));
            chk($sformatf("v%0d_b_rv", k), 32'(b_if.rvalid), 32'(vecs[k].e_b_rv));
            chk($sformatf("v%0d_b_rd", k), 32'(b_if.rdata), 32'(vecs[k].e_b_rd));
        end

        // Reset lands on a read grant: pending rvalid dropped, tie pointer back to A
        @(negedge clk);
        drive_a(1'b1, 1'b0, 3'd4, 1'b0, 8'h00);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrd_a_rvalid", 32'(a_if.rvalid), 32'd0);
        chk("midrd_a_rdata", 32'(a_if.rdata), 32'd0);
        chk("midrd_b_rdata", 32'(b_if.rdata), 32'd0);
        chk("midrd_busy", 32'(busy), 32'd1);
        rst_n = 1'b1;
        drive_b(1'b1, 1'b0, 3'd1, 1'b0, 8'h00);
        check_clear(8, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            chk($sformatf("rr%0d_a_gnt", k), 32'(a_if.gnt), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr%0d_b_gnt", k), 32'(b_if.gnt), (k % 2 == 1) ? 32'd1 : 32'd0);
            @(posedge clk);
        end

        // Reset pulse at clr_cnt=4 restarts the sweep from register 0
        @(negedge clk);
        drive_a(1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        drive_b(1'b0, 1'b0, 3'd0, 1'b0, 8'h00);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_clear(4, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check_clear(8, 0);
        @(negedge clk); #1;
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_we", 32'(rb_write_en), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
